// File: rtl/d_branch_unit_pkg.sv
// d_branch_unit_pkg -- shared types and helpers for the D-stage branch unit.
//   B_* branch type codes, B_TYPE_W, BHT reset value and the 2-bit
//   saturating counter update used by d_bht.
package d_branch_unit_pkg;

    localparam int B_TYPE_W = 3;

    typedef enum logic [B_TYPE_W-1:0] {
        B_NONE = 3'd0,
        B_BEQ  = 3'd1,
        B_BNE  = 3'd2,
        B_BLEZ = 3'd3,
        B_BGTZ = 3'd4,
        B_BLTZ = 3'd5,
        B_BGEZ = 3'd6,
        B_RSVD = 3'd7   // reserved, behaves as B_NONE
    } br_type_e;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    // Saturating 2-bit counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/d_branch_unit_if.sv
// d_branch_unit_if -- D-stage <-> branch unit signal bundle.
//   master : pipeline side, drives d_valid/d_stall/d_pc/br_type/rs_val/rt_val
//            and observes b_jump/pred_taken and the resolve record.
//   slave  : the branch unit.
interface d_branch_unit_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 32
);
    import d_branch_unit_pkg::*;

    logic                d_valid;
    logic                d_stall;
    logic [PC_W-1:0]     d_pc;
    logic [B_TYPE_W-1:0] br_type;
    logic [WIDTH-1:0]    rs_val;
    logic [WIDTH-1:0]    rt_val;
    logic                b_jump;
    logic                pred_taken;
    logic                resolve_valid;
    logic                resolve_taken;
    logic                mispredict;

    modport master (
        output d_valid, d_stall, d_pc, br_type, rs_val, rt_val,
        input  b_jump, pred_taken, resolve_valid, resolve_taken, mispredict
    );

    modport slave (
        input  d_valid, d_stall, d_pc, br_type, rs_val, rt_val,
        output b_jump, pred_taken, resolve_valid, resolve_taken, mispredict
    );

endinterface

// File: rtl/d_branch_unit_bht.sv
// d_bht -- branch history table, DEPTH x 2-bit saturating counters, no tags.
//   clk, reset : clock / synchronous active-high reset (all entries -> 2'b01)
//   rd_idx     : combinational read index
//   rd_ctr     : counter at rd_idx (value before this edge's update)
//   wr_en      : apply one saturating update at wr_idx this edge
//   wr_idx     : update index
//   wr_taken   : update direction (1 = increment, 0 = decrement)
module d_bht
    import d_branch_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [DEPTH];

    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                ctr[i] <= BHT_INIT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/d_branch_unit.sv
// d_branch_unit -- decode-stage branch resolution with a 2-bit BHT.
//   clk, reset     : clock / synchronous active-high reset
//   bus (slave)    : D-stage inputs, b_jump / pred_taken (combinational) and
//                    the registered resolve record (resolve_valid,
//                    resolve_taken, mispredict), one cycle after a fire
//   stat_branches  : resolved-branch count   (BRANCH_STAT_EN only)
//   stat_mispred   : mispredicted count      (BRANCH_STAT_EN only)
// Optional feature macro: BRANCH_STAT_EN (saturating statistics counters).
module d_branch_unit
    import d_branch_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    d_branch_unit_if.slave  bus
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             cond;
    logic             is_branch;
    logic             fire;
    logic             rs_neg;
    logic             rs_zero;
    logic [IDX_W-1:0] idx;
    logic [1:0]       ctr;

    assign rs_neg  = bus.rs_val[WIDTH-1];
    assign rs_zero = (bus.rs_val == '0);

    // Branch condition; B_NONE and the reserved code never take.
    always_comb begin
        cond      = 1'b0;
        is_branch = 1'b1;
        case (br_type_e'(bus.br_type))
            B_BEQ:   cond = (bus.rs_val == bus.rt_val);
            B_BNE:   cond = (bus.rs_val != bus.rt_val);
            B_BLEZ:  cond = rs_neg | rs_zero;
            B_BGTZ:  cond = ~rs_neg & ~rs_zero;
            B_BLTZ:  cond = rs_neg;
            B_BGEZ:  cond = ~rs_neg;
            default: is_branch = 1'b0;
        endcase
    end

    // b_jump ignores d_stall: the NPC mux is frozen by the stall anyway.
    assign bus.b_jump = bus.d_valid & cond;

    // Stalled operands may be stale, so only unstalled branches train or
    // produce a record. Reset also suppresses the fire.
    assign fire = bus.d_valid & ~bus.d_stall & is_branch & ~reset;

    assign idx            = bus.d_pc[IDX_W+1:2];
    assign bus.pred_taken = ctr[1];

    d_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_ctr   (ctr),
        .wr_en    (fire),
        .wr_idx   (idx),
        .wr_taken (bus.b_jump)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resolve_valid <= 1'b0;
            bus.resolve_taken <= 1'b0;
            bus.mispredict    <= 1'b0;
        end else begin
            bus.resolve_valid <= fire;
            bus.resolve_taken <= fire & bus.b_jump;
            bus.mispredict    <= fire & (bus.b_jump != bus.pred_taken);
        end
    end

`ifdef BRANCH_STAT_EN
    logic mp_now;
    assign mp_now = fire & (bus.b_jump != bus.pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (fire && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mp_now && stat_mispred != 32'hFFFF_FFFF)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
// tb_d_branch_unit -- self-checking bench for d_branch_unit.
// Directed scenarios plus a randomized run against a behavioural model
// (per-index integer counters, signed compares). Define BRANCH_STAT_EN to
// also exercise the statistics counters.
module tb_d_branch_unit;
    import d_branch_unit_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    d_branch_unit_if #(.WIDTH(32), .PC_W(32)) bus ();

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    d_branch_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRANCH_STAT_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    // ---------------- reference model ----------------
    int          ctr_m [DEPTH];
    bit          rv_m, rt_m, mp_m;
    logic [31:0] st_br_m, st_mp_m;
    int          vectors = 0;
    int          errors  = 0;

    function automatic bit cond_m(int t, logic [31:0] rs, logic [31:0] rt);
        case (t)
            1: return rs == rt;
            2: return rs != rt;
            3: return $signed(rs) <= 0;
            4: return $signed(rs) > 0;
            5: return $signed(rs) < 0;
            6: return $signed(rs) >= 0;
            default: return 0;
        endcase
    endfunction

    function automatic int idx_m();
        return int'((bus.d_pc >> 2) % DEPTH);
    endfunction

    function automatic bit jump_m();
        return bus.d_valid && cond_m(int'(bus.br_type), bus.rs_val, bus.rt_val);
    endfunction

    function automatic logic [4:0] exp_vec();
        return {jump_m(), ctr_m[idx_m()] >= 2, rv_m, rt_m, mp_m};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {bus.b_jump, bus.pred_taken, bus.resolve_valid, bus.resolve_taken, bus.mispredict};
    endfunction

    // Advance one clock, updating the model from the inputs present now.
    task automatic tick();
        int i;
        bit j, p, f;
        i = idx_m();
        j = jump_m();
        p = ctr_m[i] >= 2;
        f = bus.d_valid && !bus.d_stall && bus.br_type >= 1 && bus.br_type <= 6;
        @(posedge clk);
        if (reset) begin
            foreach (ctr_m[k]) ctr_m[k] = 1;
            {rv_m, rt_m, mp_m} = 3'b000;
            st_br_m = 0;
            st_mp_m = 0;
        end else begin
            rv_m = f;
            rt_m = f && j;
            mp_m = f && (j != p);
            if (f) ctr_m[i] = j ? ((ctr_m[i] < 3) ? ctr_m[i] + 1 : 3) : ((ctr_m[i] > 0) ? ctr_m[i] - 1 : 0);
            if (f && st_br_m != 32'hFFFF_FFFF) st_br_m++;
            if (f && (j != p) && st_mp_m != 32'hFFFF_FFFF) st_mp_m++;
        end
        #1;
    endtask

    task automatic drive(bit v, bit s, logic [31:0] pc, int t, logic [31:0] rs, logic [31:0] rt);
        bus.d_valid = v;
        bus.d_stall = s;
        bus.d_pc    = pc;
        bus.br_type = 3'(t);
        bus.rs_val  = rs;
        bus.rt_val  = rt;
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            drive(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom, $urandom);
            vectors++;
            if (obs_vec() !== 5'b00000) begin
                errors++;
                $display("FAIL reset_idle got %b want 00000", obs_vec());
            end
            tick();
        end
`ifdef BRANCH_STAT_EN
        vectors++;
        if ({stat_branches, stat_mispred} !== 64'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred);
        end
`endif
    endtask

    task automatic test_beq_train();
        // {valid, type, rs, rt, expected vector}
        logic [4:0] want [7] = '{5'b10000, 5'b11111, 5'b11110, 5'b11110, 5'b01110, 5'b01000, 5'b00101};
        int         typ  [7] = '{1, 1, 1, 1, 2, 2, 2};
        bit         vld  [7] = '{1, 1, 1, 1, 1, 1, 0};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            drive(vld[n], 0, 32'h3000, typ[n], 32'h1234, 32'h1234);
            // step 5 is an idle cycle so the BNE record shows before the 2nd BNE
            if (n == 5) begin
                drive(0, 0, 32'h3000, 0, 32'h1234, 32'h1234);
                vectors++;
                if (obs_vec() !== 5'b01101) begin
                    errors++;
                    $display("FAIL beq_train_bne_rec got %b want 01101", obs_vec());
                end
                tick();
                drive(1, 0, 32'h3000, 2, 32'h1234, 32'h1234);
            end
            vectors++;
            if (obs_vec() !== want[n]) begin
                errors++;
                $display("FAIL beq_train step %0d got %b want %b", n, obs_vec(), want[n]);
            end
            tick();
        end
    endtask

    task automatic test_signed();
        logic [31:0] rsv  [2] = '{32'h8000_0000, 32'h0};
        logic [3:0]  want [2] = '{4'b1010, 4'b1001};  // bit3=BLEZ .. bit0=BGEZ
        logic [3:0]  w;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            w = want[r];
            for (int t = 3; t <= 6; t++) begin
                drive(1, 0, 32'h100 + 32'(t * 4), t, rsv[r], $urandom);
                vectors++;
                if (bus.b_jump !== w[6 - t] || obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL signed type %0d rs %h got %b want jump %b vec %b", t, rsv[r], obs_vec(), w[6 - t], exp_vec());
                end
                tick();
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(1, 1, 32'h40, 1, 32'h55, 32'h55);
            vectors++;
            if (obs_vec() !== 5'b10000) begin
                errors++;
                $display("FAIL stall cycle %0d got %b want 10000", n, obs_vec());
            end
            tick();
        end
        drive(1, 0, 32'h40, 1, 32'h55, 32'h55);
        vectors++;
        if (obs_vec() !== 5'b10000) begin
            errors++;
            $display("FAIL stall_release got %b want 10000", obs_vec());
        end
        tick();
        drive(0, 0, 32'h40, 0, 32'h0, 32'h0);
        vectors++;
        if (obs_vec() !== 5'b01111) begin
            errors++;
            $display("FAIL stall_record got %b want 01111", obs_vec());
        end
        tick();
        vectors++;
        if (obs_vec() !== 5'b01000) begin
            errors++;
            $display("FAIL stall_single got %b want 01000", obs_vec());
        end
        tick();
    endtask

    task automatic test_no_fire();
        do_reset();
        drive(1, 0, 32'h80, 7, 32'h9, 32'h9);
        tick();
        drive(0, 0, 32'h80, 1, 32'h9, 32'h9);
        vectors++;
        if (obs_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL no_fire_type7 got %b want 00000", obs_vec());
        end
        tick();
        drive(0, 0, 32'h80, 0, 32'h0, 32'h0);
        vectors++;
        if (obs_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL no_fire_invalid got %b want 00000", obs_vec());
        end
        tick();
    endtask

    task automatic test_reset_fire();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(1, 0, 32'h3000, 1, 32'h7, 32'h7);
            tick();
        end
        reset = 1'b1;
        drive(1, 0, 32'h3000, 1, 32'h7, 32'h7);
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 32'(i * 4), 0, 32'h0, 32'h0);
            vectors++;
            if (obs_vec() !== 5'b00000) begin
                errors++;
                $display("FAIL reset_fire idx %0d got %b want 00000", i, obs_vec());
            end
        end
        tick();
    endtask

`ifdef BRANCH_STAT_EN
    task automatic test_stats();
        do_reset();
        drive(1, 0, 32'h4,  1, 32'h3, 32'h3); tick();  // taken, mispredicted
        drive(1, 0, 32'h8,  2, 32'h3, 32'h4); tick();  // taken, mispredicted
        drive(1, 0, 32'hC,  2, 32'h3, 32'h3); tick();  // not taken, correct
        drive(1, 0, 32'h10, 4, 32'h0, 32'h0); tick();  // not taken, correct
        drive(1, 0, 32'h14, 5, 32'h1, 32'h0); tick();  // not taken, correct
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0);
        vectors++;
        if (stat_branches !== 32'd5 || stat_mispred !== 32'd2) begin
            errors++;
            $display("FAIL stats got %0d/%0d want 5/2", stat_branches, stat_mispred);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] rs, rt;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0: begin rs = $urandom; rt = rs; end
                1: begin rs = 32'h0; rt = $urandom; end
                2: begin rs = 32'h8000_0000 | $urandom; rt = $urandom; end
                default: begin rs = $urandom; rt = $urandom; end
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  32'h3000 + 32'($urandom_range(0, 47) * 4), $urandom_range(0, 7), rs, rt);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %b want %b", n, obs_vec(), exp_vec());
            end
`ifdef BRANCH_STAT_EN
            vectors++;
            if (stat_branches !== st_br_m || stat_mispred !== st_mp_m) begin
                errors++;
                $display("FAIL random_stats cycle %0d got %0d/%0d want %0d/%0d", n, stat_branches, stat_mispred, st_br_m, st_mp_m);
            end
`endif
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        foreach (ctr_m[k]) ctr_m[k] = 1;
        {rv_m, rt_m, mp_m} = 3'b000;
        st_br_m = 0;
        st_mp_m = 0;
        test_reset();
        test_beq_train();
        test_signed();
        test_stall();
        test_no_fire();
        test_reset_fire();
`ifdef BRANCH_STAT_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
